// File: rtl/lfsr_step_arbiter.sv
// Round-robin arbiter that lends a shared 20-bit LFSR to one of three requesters
// for a programmable number of steps, then returns the captured LFSR word.
module lfsr_step_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [11:0] req_steps,
  input  logic        reseed,
  input  logic [19:0] lfsr_val,
  output logic [2:0]  ack,
  output logic [2:0]  rvalid,
  output logic [19:0] rdata,
  output logic        reseed_done,
  output logic        busy,
  output logic        lfsr_step,
  output logic        lfsr_rst
);

  typedef enum logic [1:0] {StIdle, StStep, StCapture, StReseed} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [1:0]  grant_q;
  logic [1:0]  last_q;
  logic        pend_q;

  logic        pick_valid;
  logic [1:0]  pick;
  logic [1:0]  start;
  logic [2:0]  idx;
  logic [3:0]  steps_sel;
  logic [4:0]  cnt_load;

  // Round-robin search beginning just after the most recent grant.
  always_comb begin
    pick_valid = 1'b0;
    pick       = 2'd0;
    idx        = 3'd0;
    start      = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    for (int k = 0; k < 3; k++) begin
      idx = {1'b0, start} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!pick_valid && req[idx[1:0]]) begin
        pick_valid = 1'b1;
        pick       = idx[1:0];
      end
    end
    steps_sel = req_steps[{pick, 2'b00} +: 4];
    cnt_load  = (steps_sel == 4'd0) ? 5'd16 : {1'b0, steps_sel};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 5'd0;
      grant_q     <= 2'd0;
      last_q      <= 2'd2;
      pend_q      <= 1'b0;
      ack         <= 3'b000;
      rvalid      <= 3'b000;
      rdata       <= 20'd0;
      reseed_done <= 1'b0;
    end else begin
      ack         <= 3'b000;
      rvalid      <= 3'b000;
      reseed_done <= 1'b0;
      if (reseed) pend_q <= 1'b1;
      case (state_q)
        StIdle: begin
          // A reseed, including one arriving this cycle, wins over any request.
          if (pend_q || reseed) begin
            pend_q  <= 1'b0;
            state_q <= StReseed;
          end else if (pick_valid) begin
            grant_q <= pick;
            last_q  <= pick;
            cnt_q   <= cnt_load;
            ack     <= 3'b001 << pick;
            state_q <= StStep;
          end
        end
        StStep: begin
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_q <= StCapture;
        end
        StCapture: begin
          rdata   <= lfsr_val;
          rvalid  <= 3'b001 << grant_q;
          state_q <= StIdle;
        end
        StReseed: begin
          reseed_done <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign lfsr_step = (state_q == StStep);
  assign lfsr_rst  = (state_q == StReseed);

endmodule
